lsc_core_arbiter: RTL and testbench



---
 rtl/lsc_core_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_lsc_core_arbiter.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsc_core_arbiter.sv
// Round-robin arbiter sharing one load/store controller among NUM_CORES cores.
// Define LSC_ARB_PRIO0_EN to give core 0 fixed top priority over the rotation.
module lsc_core_arbiter #(
    parameter int NUM_CORES  = 4,
    parameter int IDX_W      = 2,
    parameter int GAP_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CORES-1:0]      core_req,
    input  logic [NUM_CORES-1:0]      core_rwn,
    input  logic [40*NUM_CORES-1:0]   core_hostAddr,
    input  logic [12*NUM_CORES-1:0]   core_localAddr,
    input  logic [16*NUM_CORES-1:0]   core_transferLength,
    input  logic [128*NUM_CORES-1:0]  core_writeData,
    output logic [NUM_CORES-1:0]      core_ready,
    output logic [NUM_CORES-1:0]      core_ack,
    output logic [127:0]              core_readData,
    output logic [11:0]               core_readAddr,
    output logic                      lsc_req,
    output logic                      lsc_rwn,
    output logic [39:0]               lsc_hostAddr,
    output logic [11:0]               lsc_localAddr,
    output logic [15:0]               lsc_transferLength,
    output logic [127:0]              lsc_writeData,
    input  logic                      lsc_ready,
    input  logic                      lsc_ack,
    input  logic [127:0]              lsc_readData,
    input  logic [11:0]               lsc_readAddr,
    output logic                      busy,
    output logic [IDX_W-1:0]          grant_id,
    output logic [15:0]               beat_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_OWN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [15:0]      beat_q, beat_d;
    logic [3:0]       gap_q, gap_d;

    logic [IDX_W:0]   cand;
    logic [IDX_W-1:0] win_idx;
    logic             win_vld;

    logic             own_req;
    logic             own_rwn;
    logic [39:0]      own_haddr;
    logic [11:0]      own_laddr;
    logic [15:0]      own_len;
    logic [127:0]     own_wdata;

    logic             in_own;
    logic             routed;

    assign in_own = (state_q == S_OWN);
    assign routed = (state_q == S_OWN) || (state_q == S_DRAIN);

    // Rotating scan starting one past the last owner.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
`ifdef LSC_ARB_PRIO0_EN
        if (core_req[0]) begin
            win_vld = 1'b1;
            win_idx = '0;
        end
`endif
        for (int k = 0; k < NUM_CORES; k++) begin
            cand = {1'b0, last_q} + (IDX_W+1)'(k + 1);
            if (cand >= (IDX_W+1)'(NUM_CORES))
                cand = cand - (IDX_W+1)'(NUM_CORES);
            if (!win_vld && core_req[cand[IDX_W-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        own_req   = 1'b0;
        own_rwn   = 1'b0;
        own_haddr = '0;
        own_laddr = '0;
        own_len   = '0;
        own_wdata = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (grant_q == IDX_W'(i)) begin
                own_req   = core_req[i];
                own_rwn   = core_rwn[i];
                own_haddr = core_hostAddr[40*i +: 40];
                own_laddr = core_localAddr[12*i +: 12];
                own_len   = core_transferLength[16*i +: 16];
                own_wdata = core_writeData[128*i +: 128];
            end
        end
    end

    always_comb begin
        core_ready = '0;
        core_ack   = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (routed && grant_q == IDX_W'(i)) begin
                core_ready[i] = lsc_ready;
                core_ack[i]   = lsc_ack;
            end
        end
    end

    assign lsc_req            = in_own & own_req;
    assign lsc_rwn            = in_own & own_rwn;
    assign lsc_hostAddr       = in_own ? own_haddr : '0;
    assign lsc_localAddr      = in_own ? own_laddr : '0;
    assign lsc_transferLength = in_own ? own_len   : '0;
    assign lsc_writeData      = in_own ? own_wdata : '0;

    assign core_readData = lsc_readData;
    assign core_readAddr = lsc_readAddr;
    assign busy          = (state_q != S_IDLE);
    assign grant_id      = grant_q;
    assign beat_cnt      = beat_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        beat_d  = beat_q;
        gap_d   = gap_q;
        if (routed && lsc_ack && beat_q != 16'hFFFF)
            beat_d = beat_q + 16'd1;
        unique case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    grant_d = win_idx;
                    beat_d  = '0;
                    state_d = S_OWN;
                end
            end
            S_OWN: begin
                if (!own_req)
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // Let the controller fall back to idle before re-arbitrating.
                if (!lsc_ready) begin
                    gap_d   = 4'(GAP_CYCLES);
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q <= 4'd1) begin
                    last_d  = grant_q;
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_CORES - 1);
            beat_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
            gap_q   <= gap_d;
        end
    end

endmodule

// File: tb/tb_lsc_core_arbiter.sv
// Scoreboard bench for lsc_core_arbiter: core and controller models drive
// random transactions; a monitor checks grants against a rotation model.
module tb_lsc_core_arbiter;

    localparam int N   = 4;
    localparam int IW  = 2;
    localparam int GAP = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [N-1:0]      core_req;
    logic [N-1:0]      core_rwn;
    logic [40*N-1:0]   core_hostAddr;
    logic [12*N-1:0]   core_localAddr;
    logic [16*N-1:0]   core_transferLength;
    logic [128*N-1:0]  core_writeData;
    logic [N-1:0]      core_ready;
    logic [N-1:0]      core_ack;
    logic [127:0]      core_readData;
    logic [11:0]       core_readAddr;
    logic              lsc_req;
    logic              lsc_rwn;
    logic [39:0]       lsc_hostAddr;
    logic [11:0]       lsc_localAddr;
    logic [15:0]       lsc_transferLength;
    logic [127:0]      lsc_writeData;
    logic              lsc_ready;
    logic              lsc_ack;
    logic [127:0]      lsc_readData;
    logic [11:0]       lsc_readAddr;
    logic              busy;
    logic [IW-1:0]     grant_id;
    logic [15:0]       beat_cnt;

    lsc_core_arbiter #(.NUM_CORES(N), .IDX_W(IW), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req), .core_rwn(core_rwn),
        .core_hostAddr(core_hostAddr), .core_localAddr(core_localAddr),
        .core_transferLength(core_transferLength),
        .core_writeData(core_writeData),
        .core_ready(core_ready), .core_ack(core_ack),
        .core_readData(core_readData), .core_readAddr(core_readAddr),
        .lsc_req(lsc_req), .lsc_rwn(lsc_rwn),
        .lsc_hostAddr(lsc_hostAddr), .lsc_localAddr(lsc_localAddr),
        .lsc_transferLength(lsc_transferLength),
        .lsc_writeData(lsc_writeData),
        .lsc_ready(lsc_ready), .lsc_ack(lsc_ack),
        .lsc_readData(lsc_readData), .lsc_readAddr(lsc_readAddr),
        .busy(busy), .grant_id(grant_id), .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           id;
        logic         rwn;
        logic [39:0]  ha;
        logic [11:0]  la;
        logic [15:0]  len;
        logic [127:0] wd;
    } txn_t;

    txn_t exp_q[$];
    txn_t cur;

    int n_chk;
    int n_fail;
    int done_cnt;
    int last_m;
    int cyc;

    logic         f_rwn [N];
    logic [39:0]  f_ha  [N];
    logic [11:0]  f_la  [N];
    logic [15:0]  len_a [N];
    logic [127:0] f_wd  [N];

    logic [N-1:0] cmd_mask;
    int           cmd_rep0;
    int           cmd_seq;
    int           exp_n;
    int           base_done;

    task automatic chk_eq(input string name, input logic [159:0] act,
                          input logic [159:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    task automatic chk_ge(input string name, input int act, input int lim);
        n_chk++;
        if (act < lim) begin
            n_fail++;
            $display("FAIL %s: got %0d expected at least %0d", name, act, lim);
        end
    endtask

    // Reference: next owner is the first pending core after the last one.
    function automatic int pick(input logic [N-1:0] pend);
`ifdef LSC_ARB_PRIO0_EN
        if (pend[0]) return 0;
`endif
        for (int k = 1; k <= N; k++) begin
            if (pend[(last_m + k) % N]) return (last_m + k) % N;
        end
        return -1;
    endfunction

    task automatic driver();
        int     got [N];
        int     ctl_beats;
        int     rep0;
        int     seen_seq;
        logic   restart0;
        logic   req_s;
        logic [15:0] len_s;
        core_req     = '0;
        lsc_ready    = 1'b0;
        lsc_ack      = 1'b0;
        lsc_readData = '0;
        lsc_readAddr = '0;
        ctl_beats    = 0;
        rep0         = 0;
        seen_seq     = 0;
        restart0     = 1'b0;
        for (int i = 0; i < N; i++) got[i] = 0;
        forever begin
            @(negedge clk);
            req_s = lsc_req;
            len_s = lsc_transferLength;
            for (int i = 0; i < N; i++)
                if (core_req[i] && core_ack[i]) got[i]++;
            if (lsc_req && lsc_ack) ctl_beats++;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                core_req  = '0;
                lsc_ready = 1'b0;
                lsc_ack   = 1'b0;
                ctl_beats = 0;
                rep0      = 0;
                restart0  = 1'b0;
                seen_seq  = cmd_seq;
                continue;
            end
            for (int i = 0; i < N; i++) begin
                if (core_req[i]) begin
                    if (got[i] >= int'(len_a[i])) begin
                        core_req[i] = 1'b0;
                        if (i == 0 && rep0 > 0) begin
                            rep0--;
                            restart0 = 1'b1;
                        end
                    end
                end else if (i == 0 && restart0) begin
                    core_req[0] = 1'b1;
                    got[0]      = 0;
                    restart0    = 1'b0;
                end
            end
            if (cmd_seq != seen_seq) begin
                seen_seq = cmd_seq;
                rep0     = cmd_rep0;
                for (int i = 0; i < N; i++) begin
                    if (cmd_mask[i]) begin
                        core_req[i] = 1'b1;
                        got[i]      = 0;
                    end
                end
            end
            if (req_s) begin
                lsc_ready    = 1'b1;
                lsc_ack      = (ctl_beats < int'(len_s)) &&
                               ($urandom_range(0, 1) == 1);
                lsc_readData = {$urandom, $urandom, $urandom, $urandom};
                lsc_readAddr = 12'($urandom);
            end else begin
                lsc_ack   = 1'b0;
                ctl_beats = 0;
                if (lsc_ready && $urandom_range(0, 1) == 1)
                    lsc_ready = 1'b0;
            end
        end
    endtask

    task automatic monitor();
        logic         pbusy;
        logic         in_txn;
        logic         had_req;
        int           last_req_cyc;
        logic [N-1:0] own;
        pbusy        = 1'b0;
        in_txn       = 1'b0;
        had_req      = 1'b0;
        last_req_cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                pbusy   = 1'b0;
                in_txn  = 1'b0;
                had_req = 1'b0;
                continue;
            end
            chk_eq("bcast", {core_readAddr, core_readData},
                   {lsc_readAddr, lsc_readData});
            if (!busy)
                chk_eq("idle_out", {lsc_req, lsc_rwn, lsc_hostAddr,
                       lsc_localAddr, lsc_transferLength, |lsc_writeData}, '0);
            if (busy && !pbusy) begin
                if (exp_q.size() == 0) begin
                    chk_eq("unexpected_grant", 160'(grant_id), '1);
                end else begin
                    cur    = exp_q.pop_front();
                    in_txn = 1'b1;
                    chk_eq("grant_id", 160'(grant_id), 160'(cur.id));
                    chk_eq("beat_clr", 160'(beat_cnt), '0);
                    if (cur.len == 0) begin
                        chk_eq("zero_req", 160'(lsc_req), '0);
                    end else begin
                        chk_eq("grant_req", 160'(lsc_req), 160'(1));
                        if (had_req)
                            chk_ge("gap", cyc - last_req_cyc - 1, GAP + 2);
                    end
                end
            end
            if (in_txn) begin
                own = N'(1) << cur.id;
                if (lsc_req) begin
                    chk_eq("fields",
                           {lsc_rwn, lsc_hostAddr, lsc_localAddr,
                            lsc_transferLength},
                           {cur.rwn, cur.ha, cur.la, cur.len});
                    chk_eq("wdata", 160'(lsc_writeData), 160'(cur.wd));
                    chk_eq("route", {core_ready, core_ack},
                           {lsc_ready ? own : '0, lsc_ack ? own : '0});
                end else begin
                    chk_eq("route_own", {core_ready & ~own, core_ack & ~own},
                           '0);
                end
            end else begin
                chk_eq("route_none", {core_ready, core_ack}, '0);
            end
            if (lsc_req) begin
                had_req      = 1'b1;
                last_req_cyc = cyc;
            end
            if (!busy && pbusy && in_txn) begin
                chk_eq("beat_cnt", 160'(beat_cnt), 160'(cur.len));
                chk_eq("grant_hold", 160'(grant_id), 160'(cur.id));
                in_txn = 1'b0;
                done_cnt++;
            end
            pbusy = busy;
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy || core_req != '0) && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (k >= 500) chk_eq("idle_timeout", 160'(busy), '0);
    endtask

    task automatic issue_batch(input logic [N-1:0] mask, input int rep,
                               input int flen, input int frwn,
                               input logic chk_lat);
        logic [N-1:0] pend;
        logic [63:0]  r64;
        int           r;
        int           w;
        txn_t         t;
        wait_idle();
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                r64      = {$urandom, $urandom};
                f_rwn[i] = (frwn >= 0) ? frwn[0] : 1'($urandom);
                f_ha[i]  = r64[39:0];
                f_la[i]  = 12'($urandom);
                f_wd[i]  = {$urandom, $urandom, $urandom, $urandom};
                len_a[i] = (flen >= 0) ? 16'(flen) : 16'($urandom_range(1, 4));
                core_rwn[i]                   = f_rwn[i];
                core_hostAddr[40*i +: 40]     = f_ha[i];
                core_localAddr[12*i +: 12]    = f_la[i];
                core_transferLength[16*i +: 16] = len_a[i];
                core_writeData[128*i +: 128]  = f_wd[i];
            end
        end
        pend  = mask;
        r     = rep;
        exp_n = 0;
        while (pend != '0) begin
            w     = pick(pend);
            t.id  = w;
            t.rwn = f_rwn[w];
            t.ha  = f_ha[w];
            t.la  = f_la[w];
            t.len = len_a[w];
            t.wd  = f_wd[w];
            exp_q.push_back(t);
            exp_n++;
            last_m = w;
            if (w == 0 && r > 0) r--;
            else pend[w] = 1'b0;
        end
        base_done = done_cnt;
        cmd_mask  = mask;
        cmd_rep0  = rep;
        cmd_seq++;
        if (chk_lat) begin
            @(negedge clk);
            chk_eq("lat_idle", {core_req, lsc_req}, {mask, 1'b0});
            @(negedge clk);
            chk_eq("lat_grant", 160'(lsc_req), 160'(1));
        end
    endtask

    task automatic wait_batch();
        int k;
        k = 0;
        while (done_cnt < base_done + exp_n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) begin
            chk_eq("batch_timeout", 160'(done_cnt), 160'(base_done + exp_n));
            exp_q.delete();
        end
    endtask

    task automatic run_batch(input logic [N-1:0] mask, input int rep,
                             input int flen, input int frwn,
                             input logic chk_lat);
        issue_batch(mask, rep, flen, frwn, chk_lat);
        wait_batch();
    endtask

    initial begin
        logic [N-1:0] m;
        int k;
        n_chk = 0;
        n_fail = 0;
        done_cnt = 0;
        cyc = 0;
        last_m = N - 1;
        cmd_mask = '0;
        cmd_rep0 = 0;
        cmd_seq = 0;
        exp_n = 0;
        base_done = 0;
        core_rwn = '0;
        core_hostAddr = '0;
        core_localAddr = '0;
        core_transferLength = '0;
        core_writeData = '0;
        for (int i = 0; i < N; i++) begin
            f_rwn[i] = 1'b0;
            f_ha[i]  = '0;
            f_la[i]  = '0;
            len_a[i] = '0;
            f_wd[i]  = '0;
        end
        fork
            driver();
            monitor();
        join_none
        #22;
        chk_eq("reset_vals", {lsc_req, lsc_rwn, lsc_hostAddr, lsc_localAddr,
               lsc_transferLength, |lsc_writeData, core_ready, core_ack,
               busy, grant_id, beat_cnt}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        run_batch(4'b1011, 0, 3, -1, 1'b0);
        run_batch(4'b0100, 0, 3, 0, 1'b1);
        run_batch(4'b0010, 0, 2, 1, 1'b0);
        run_batch(4'b1000, 0, 0, -1, 1'b0);
        @(negedge clk);
        chk_eq("zero_idle", 160'(busy), '0);

        for (int t = 0; t < 10; t++) begin
            m = N'($urandom_range(1, (1 << N) - 1));
            run_batch(m, m[0] ? $urandom_range(0, 2) : 0, -1, -1, 1'b0);
        end

        issue_batch(4'b0110, 0, 4, -1, 1'b0);
        k = 0;
        while (!lsc_req && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk_eq("pre_reset_own", 160'(lsc_req), 160'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk_eq("reset_async", {lsc_req, lsc_rwn, lsc_hostAddr, lsc_localAddr,
               lsc_transferLength, |lsc_writeData, core_ready, core_ack,
               busy, grant_id, beat_cnt}, '0);
        exp_q.delete();
        last_m = N - 1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_batch(4'b0101, 1, -1, -1, 1'b0);
        run_batch(4'b0101, 2, -1, -1, 1'b0);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
